// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned OFF_W    = 8;
    localparam int unsigned NUM_PROG = 4;
    localparam int unsigned PSEL_W   = 2;

    typedef logic [ADDR_W-1:0] iaddr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam iaddr_t PROG_BASE [NUM_PROG] = '{10'd0, 10'd256, 10'd512, 10'd768};

    // Entry point lookup; callers only pass in-range indices.
    function automatic iaddr_t prog_base(input logic [PSEL_W-1:0] sel);
        return PROG_BASE[int'(sel)];
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: start entry, hold, branch, or increment.
module pc_next_calc
    import fetch_pkg::*;
(
    input  logic              i_run,
    input  logic              i_start_ok,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_halt,
    input  logic              i_stall,
    input  logic              i_branch_en,
    input  logic              i_branch_rel,
    input  logic [ADDR_W-1:0] i_target,
    input  logic [OFF_W-1:0]  i_offset,
    output logic [ADDR_W-1:0] o_next_pc_c,
    output logic              o_overflow_c
);

    logic [ADDR_W-1:0] w_offset_sext;
    logic [ADDR_W-1:0] w_rel_pc;

    // Relative branches wrap modulo the ROM depth.
    assign w_offset_sext = {{(ADDR_W-OFF_W){i_offset[OFF_W-1]}}, i_offset};
    assign w_rel_pc      = i_pc + w_offset_sext;

    always_comb begin
        o_next_pc_c  = i_pc;
        o_overflow_c = 1'b0;
        if (i_start_ok) begin
            o_next_pc_c = i_base;
        end else if (i_run) begin
            if (i_halt || i_stall) begin
                o_next_pc_c = i_pc;
            end else if (i_branch_en) begin
                o_next_pc_c = i_branch_rel ? w_rel_pc : i_target;
            end else if (i_pc == {ADDR_W{1'b1}}) begin
                o_overflow_c = 1'b1;
            end else begin
                o_next_pc_c = i_pc + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer owning the instruction ROM address bus.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PSEL_W-1:0] ProgSel,
    input  logic              Stall,
    input  logic              BranchEn,
    input  logic              BranchRel,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic [OFF_W-1:0]  BranchOffset,
    input  logic              Halt,
    output logic [ADDR_W-1:0] InstAddress,
    output logic              Fetching,
    output logic              Ack,
    output logic              Fault
);

    localparam int unsigned SEL_CMP_W = PSEL_W + 1;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fetching;
    logic              r_ack;
    logic              r_fault;

    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_ack_nxt;
    logic              w_fault_nxt;
    logic              w_start_ok;
    logic              w_run;
    logic              w_overflow;
    logic [ADDR_W-1:0] w_base;

    // Out-of-range program indices make Start a no-op.
    assign w_start_ok = Start && ({1'b0, ProgSel} < SEL_CMP_W'(NUM_PROG));
    assign w_run      = (r_state == RUN);
    assign w_base     = w_start_ok ? prog_base(ProgSel) : '0;

    pc_next_calc u_pc_next_calc (
        .i_run        (w_run),
        .i_start_ok   (w_start_ok),
        .i_pc         (r_pc),
        .i_base       (w_base),
        .i_halt       (Halt),
        .i_stall      (Stall),
        .i_branch_en  (BranchEn),
        .i_branch_rel (BranchRel),
        .i_target     (BranchTarget),
        .i_offset     (BranchOffset),
        .o_next_pc_c  (w_pc_nxt),
        .o_overflow_c (w_overflow)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_fetching <= 1'b0;
            r_ack      <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fetching <= (w_state_nxt == RUN);
            r_ack      <= w_ack_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    // Start outranks everything; otherwise only RUN reacts to requests.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_fault_nxt = r_fault;
        if (w_start_ok) begin
            w_state_nxt = RUN;
            w_ack_nxt   = 1'b0;
            w_fault_nxt = 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (Halt) begin
                        w_state_nxt = DONE;
                        w_ack_nxt   = 1'b1;
                    end else if (w_overflow) begin
                        w_state_nxt = DONE;
                        w_ack_nxt   = 1'b1;
                        w_fault_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign InstAddress = r_pc;
    assign Fetching    = r_fetching;
    assign Ack         = r_ack;
    assign Fault       = r_fault;

endmodule
